// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM state
// encoding and bit positions inside the 4-bit flags vector.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int F_NEG   = 3;
  localparam int F_ZERO  = 2;
  localparam int F_CARRY = 1;
  localparam int F_OVF   = 0;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational result and flag generation for every single-cycle opcode.
// MUL yields zero here; the sequential wrapper computes it over several cycles.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             ovf;

  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // The extra top bit catches a[WIDTH-shamt], the last bit pushed out.
  assign shl   = {1'b0, a} << shamt;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_PASS: res = a;
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res   = shl[WIDTH-1:0];
        carry = shl[WIDTH];
      end
      default: res = '0;
    endcase
    flags          = '0;
    flags[F_NEG]   = res[WIDTH-1];
    flags[F_ZERO]  = (res == '0);
    flags[F_CARRY] = carry;
    flags[F_OVF]   = ovf;
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle ops register in one edge, MUL runs a
// shift-add loop for WIDTH cycles; results are held until the consumer takes them.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW+2*WIDTH-1:0] incode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       ans,
  output logic [WIDTH-1:0]       ans_hi,
  output logic [3:0]             flags
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds incode stable and the unit holds ans/ans_hi/flags
  // stable while its valid is high and the partner's ready is low.

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

  state_t              state;
  state_t              next_state;
  logic [OPW-1:0]      op_in;
  logic [WIDTH-1:0]    a_in;
  logic [WIDTH-1:0]    b_in;
  logic [WIDTH-1:0]    core_res;
  logic [3:0]          core_flags;
  logic                accept;
  logic [WIDTH-1:0]    mcand;
  logic [2*WIDTH-1:0]  prod;
  logic [2*WIDTH-1:0]  prod_next;
  logic [WIDTH:0]      step_sum;
  logic [SHW:0]        cnt;
  logic [3:0]          mul_flags;

  assign op_in  = incode[OPW+2*WIDTH-1:2*WIDTH];
  assign a_in   = incode[2*WIDTH-1:WIDTH];
  assign b_in   = incode[WIDTH-1:0];
  assign accept = in_valid && in_ready;

  alu_comb_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op    (op_in),
    .a     (a_in),
    .b     (b_in),
    .res   (core_res),
    .flags (core_flags)
  );

  // Upper half accumulates; the multiplier sits in the lower half and is
  // shifted out LSB first as the partial sum shifts in from the top.
  assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
  assign prod_next = {step_sum, prod[WIDTH-1:1]};

  always_comb begin
    mul_flags          = '0;
    mul_flags[F_NEG]   = prod_next[WIDTH-1];
    mul_flags[F_ZERO]  = (prod_next[WIDTH-1:0] == '0);
    mul_flags[F_CARRY] = (prod_next[2*WIDTH-1:WIDTH] != '0);
    mul_flags[F_OVF]   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (accept) begin
      next_state = (op_in == OP_MUL) ? S_MUL : S_DONE;
    end else begin
      case (state)
        S_IDLE:  next_state = S_IDLE;
        S_MUL:   next_state = (cnt == CNT_LAST) ? S_DONE : S_MUL;
        S_DONE:  next_state = out_ready ? S_IDLE : S_DONE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = rst_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans    <= '0;
      ans_hi <= '0;
      flags  <= '0;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
    end else if (accept) begin
      if (op_in == OP_MUL) begin
        mcand <= a_in;
        prod  <= {{WIDTH{1'b0}}, b_in};
        cnt   <= '0;
      end else begin
        ans    <= core_res;
        ans_hi <= '0;
        flags  <= core_flags;
      end
    end else if (state == S_MUL) begin
      prod <= prod_next;
      cnt  <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        ans    <= prod_next[WIDTH-1:0];
        ans_hi <= prod_next[2*WIDTH-1:WIDTH];
        flags  <= mul_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases from the ALU's own
// arithmetic rules, then randomized ops with random consumer stalls.
module tb_alu_seq_unit;

  localparam int W  = 8;
  localparam int RW = 2*W + 4;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [3+2*W-1:0] incode = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   ans;
  logic [W-1:0]   ans_hi;
  logic [3:0]     flags;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .incode    (incode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans),
    .ans_hi    (ans_hi),
    .flags     (flags)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [RW-1:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Returns {ans_hi, ans, neg, zero, carry, ovf} from plain integer arithmetic.
  function automatic logic [RW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint m  = longint'(1) << W;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m/2) ? ua - m : ua;
    longint sb = (ub >= m/2) ? ub - m : ub;
    longint r  = 0;
    longint hi = 0;
    longint sr = 0;
    int     sh = int'(ub % W);
    bit     c  = 0;
    bit     v  = 0;
    case (op)
      3'd0: r = ua;
      3'd1: begin
        r = ua + ub; c = (r >= m); r = r % m;
        sr = sa + sb; v = (sr >= m/2) || (sr < -(m/2));
      end
      3'd2: begin
        c = (ua < ub); r = (ua - ub + m) % m;
        sr = sa - sb; v = (sr >= m/2) || (sr < -(m/2));
      end
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: begin
        r = (ua * ub) % m; hi = (ua * ub) / m; c = (hi != 0);
      end
      default: begin
        r = (ua << sh) % m;
        c = (sh != 0) && (((ua >> (W - sh)) & 1) == 1);
      end
    endcase
    return {hi[W-1:0], r[W-1:0], (r >= m/2), (r == 0), c, v};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_without_op", {31'd0, out_valid}, 32'd0);
      end else begin
        check("result", {12'd0, ans_hi, ans, flags}, {12'd0, exp_q[0]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    incode   = {op, a, b};
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(model(op, a, b));
      in_valid = 1'b0;
    end
  endtask

  // Negedges from the accept edge until out_valid is seen (1 = next cycle).
  task automatic wait_valid(output int n, input bit check_busy);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (check_busy && !out_valid) check("in_ready_during_mul", {31'd0, in_ready}, 32'd0);
    end while (!out_valid && n < 100);
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] e_ans,
                           input logic [W-1:0] e_hi, input logic [3:0] e_flags);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_ans"},   {24'd0, ans},       {24'd0, e_ans});
    check({name, "_hi"},    {24'd0, ans_hi},    {24'd0, e_hi});
    check({name, "_flags"}, {28'd0, flags},     {28'd0, e_flags});
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  int n;
  int c0;
  int h0;
  bit rand_done = 0;
  logic [RW-1:0] mres;
  logic [W-1:0] corner[4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    incode = {3'b001, 8'h23, 8'h16};
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_ans",       {24'd0, ans},       32'd0);
      check("rst_flags",     {28'd0, flags},     32'd0);
    end
    in_valid = 1'b0;
    align();
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Pin the model itself with hand-computed values.
    mres = model(3'd3, 8'h23, 8'h16); check("model_and", {24'd0, mres[W+3:4]}, 32'h02);
    mres = model(3'd4, 8'h23, 8'h16); check("model_or",  {24'd0, mres[W+3:4]}, 32'h37);
    mres = model(3'd5, 8'h23, 8'h16); check("model_xor", {24'd0, mres[W+3:4]}, 32'h35);
    mres = model(3'd7, 8'h23, 8'h16); check("model_shl", {12'd0, mres}, {12'd0, 8'h00, 8'hC0, 4'b1000});
    mres = model(3'd6, 8'h23, 8'h16); check("model_mul", {12'd0, mres}, {12'd0, 8'h03, 8'h02, 4'b0010});

    align();
    send(3'd1, 8'h23, 8'h16);
    wait_valid(n, 0);
    check("add_latency", n, 1);
    check_lit("add", 8'h39, 8'h00, 4'b0000);

    align();
    send(3'd2, 8'h23, 8'h16);
    wait_valid(n, 0);
    check_lit("sub", 8'h0D, 8'h00, 4'b0000);

    // Back-to-back: every op accepted on consecutive edges.
    align();
    c0 = cyc; h0 = hs_count;
    send(3'd3, 8'h23, 8'h16);
    send(3'd4, 8'h23, 8'h16);
    send(3'd5, 8'h23, 8'h16);
    send(3'd7, 8'h23, 8'h16);
    send(3'd1, 8'h23, 8'h16);
    send(3'd2, 8'h23, 8'h16);
    check("b2b_accept_cycles", cyc - c0, 6);
    repeat (2) @(negedge clk);
    check("b2b_results", hs_count - h0, 6);

    align();
    send(3'd6, 8'h23, 8'h16);
    wait_valid(n, 1);
    check("mul_latency", n, 9);
    check_lit("mul", 8'h02, 8'h03, 4'b0010);

    align();
    send(3'd1, 8'h7F, 8'h01);
    wait_valid(n, 0);
    check_lit("add_ovf", 8'h80, 8'h00, 4'b1001);
    align();
    send(3'd1, 8'hFF, 8'h01);
    wait_valid(n, 0);
    check_lit("add_carry", 8'h00, 8'h00, 4'b0110);
    align();
    send(3'd2, 8'h00, 8'h01);
    wait_valid(n, 0);
    check_lit("sub_borrow", 8'hFF, 8'h00, 4'b1010);

    // Backpressure: result held, new instruction refused.
    align();
    out_ready = 1'b0;
    send(3'd1, 8'h23, 8'h16);
    in_valid = 1'b1;
    incode   = {3'b101, 8'hAA, 8'h55};
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_ans",      {24'd0, ans},      32'h39);
      check("stall_flags",    {28'd0, flags},    32'd0);
    end
    align();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_drained", exp_q.size(), 0);

    // Reset in the middle of a MUL: result dropped, next op fine.
    align();
    send(3'd6, 8'hA5, 8'h3C);
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    align();
    send(3'd1, 8'h10, 8'h20);
    wait_valid(n, 0);
    check("post_abort_latency", n, 1);
    check_lit("post_abort", 8'h30, 8'h00, 4'b0000);

    // Randomized ops with a randomly stalling consumer.
    align();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [2:0] op;
          logic [W-1:0] a;
          logic [W-1:0] b;
          op = 3'($urandom_range(0, 7));
          a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
          b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
          send(op, a, b);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    align();
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, clocked successor to the 8-bit combinational ALU control unit.
- Accepts one packed instruction word {op, a, b} per valid/ready handshake and returns a registered result, upper product half and status flags through a valid/ready output handshake.
- Single-cycle ops complete in one cycle. MUL is multi-cycle shift-add, so no WIDTH×WIDTH multiplier is needed.
- Sits between the instruction source (bench or future decoder) and the register/writeback logic.

Parameters:
- WIDTH, 8, operand/result width (≥2, power of two).
- OPW, 3, opcode field width (fixed encoding below; must be 3).
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  unit can accept an instruction this cycle.
- incode  in  OPW+2*WIDTH  {op[OPW-1:0], a[WIDTH-1:0], b[WIDTH-1:0]}, op in MSBs (19 bits at default).
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- ans  out  WIDTH  result (low half for MUL).
- ans_hi  out  WIDTH  upper product half for MUL, 0 for all other ops.
- flags  out  4  {neg, zero, carry, ovf}.

Behaviour:
- Opcodes: 000 PASS (ans=a), 001 ADD, 010 SUB (a-b), 011 AND, 100 OR, 101 XOR, 110 MUL (unsigned), 111 SHL (a << b[SHW-1:0]).
- Flag rules:
  - zero = (ans==0); neg = ans[WIDTH-1]. For MUL, zero and neg are computed on ans (low half) only.
  - ADD: carry = carry-out; ovf = signed overflow.
  - SUB: carry = borrow (a<b unsigned); ovf = signed overflow.
  - MUL: carry = (ans_hi!=0); ovf = 0.
  - SHL: carry = last bit shifted out (a[WIDTH-shamt]), 0 when shamt=0; ovf = 0.
  - PASS/logic ops: carry = ovf = 0.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid, capture a, b, op.
    - Non-MUL: result computed and registered that edge, go to DONE.
    - MUL: clear accumulator, counter=0, go to MUL.
  - MUL: one multiplier bit per cycle (LSB first); in_ready=0; in_valid ignored. After WIDTH iterations, register ans/ans_hi/flags and go to DONE.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0.
    - On out_ready: if in_valid also high, the new instruction is accepted in the same cycle (back-to-back) and handled as from IDLE. Otherwise go to IDLE.
  - in_ready = rst_n && (state==IDLE || (state==DONE && out_ready)).
- Latency, accept edge t:
  - Non-MUL: out_valid from t+1.
  - MUL: out_valid from t+1+WIDTH.
- Throughput: one non-MUL op per cycle when the consumer never stalls.
- Arithmetic: all unsigned WIDTH-bit wrap; ADD/SUB use a WIDTH+1-bit internal sum; MUL accumulator is 2*WIDTH bits.
- Reset, sampled on clk while rst_n=0:
  - state=IDLE.
  - ans, ans_hi, flags, out_valid, counter = 0.
  - in_ready=0 while rst_n low.
- Reset mid-MUL or mid-DONE aborts the op; the result is discarded and no out_valid pulse follows.
- in_valid while in_ready=0 is not accepted; the source must hold incode stable until the handshake completes.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_PASS … OP_SHL).
  - state encoding (S_IDLE, S_MUL, S_DONE).
  - flag bit indices (F_NEG=3, F_ZERO=2, F_CARRY=1, F_OVF=0).
- One sub-module: alu_comb_core. It is purely combinational, WIDTH-parametrised, and computes result + flags for all single-cycle ops.
- The FSM, MUL iterator and output registers live in alu_seq_unit.

Test Plan:
- Reset hold 3 cycles with in_valid=1 → in_ready=0, out_valid=0, ans=0, flags=0. First cycle after release: in_ready=1.
- ADD, incode=19'b001_00100011_00010110 (a=0x23, b=0x16), out_ready=1 → one cycle later ans=0x39, flags=0000. Same operands with SUB (010) → ans=0x0D, flags=0000.
- Logic/shift, same operands:
  - AND → 0x02.
  - OR → 0x37.
  - XOR → 0x35.
  - SHL (shamt 6) → ans=0xC0, flags neg=1, carry=0.
  - Issued back-to-back, one result per cycle.
- MUL 0x23×0x16 → out_valid exactly 9 cycles after accept, ans=0x02, ans_hi=0x03, carry=1; in_ready=0 throughout MUL.
- Boundaries:
  - ADD 0x7F+0x01 → ans=0x80, neg=1, ovf=1.
  - ADD 0xFF+0x01 → ans=0x00, zero=1, carry=1.
  - SUB 0x00-0x01 → ans=0xFF, carry=1.
- Backpressure/abort:
  - out_ready=0 for 5 cycles in DONE → ans/flags stable, in_ready=0.
  - rst_n pulled low at cycle 4 of MUL → no out_valid; the next op completes normally.
